dac_output_buffer: RTL and testbench
====================================

# dac_output_buffer

Elastic sample buffer and DAC pacer between the OFDM upconverter's real output and the DAC pins. It accepts bursty 16-bit real samples with a valid strobe and stores them in a FIFO. After a prefill threshold is reached, it emits one sample every RATE_DIV clocks on a registered DAC bus. When no data is available it holds the DAC at mid-scale and reports overflow and underflow through sticky flags.

## Interface
- ADDR_W, 4: FIFO address width; depth = 2**ADDR_W.
- RATE_DIV, 4: clocks per DAC sample (≥2).
- PREFILL_LEVEL, 8: fill needed before streaming starts (1..2**ADDR_W).
- clk_in  in  1  single system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  block enable; low flushes and idles.
- sample_in  in  16  upconverter real output, two's complement sfix16.
- sample_valid  in  1  sample_in valid this cycle.
- clear_flags  in  1  one-cycle pulse clears overflow and underflow.
- dac_data  out  16  registered DAC word.
- dac_strobe  out  1  one-cycle pulse when dac_data updates.
- fill_level  out  ADDR_W+1  current FIFO occupancy.
- streaming  out  1  high in STREAM state.
- overflow  out  1  sticky: a sample was dropped on a full FIFO.
- underflow  out  1  sticky: FIFO was empty at a STREAM strobe.

## Operation
- Reset values:
  - dac_data = MID (see Configuration).
  - dac_strobe = 0, fill_level = 0, streaming = 0, overflow = 0, underflow = 0.
  - FSM = IDLE; pointers and pace counter = 0.
- Write side:
  - sample_valid & enable & !full writes sample_in at the clock edge.
  - full is evaluated before any same-cycle pop, so valid while full drops the sample and sets overflow, even if a pop occurs on the same edge.
- Pace counter:
  - Counts 0..RATE_DIV-1 while enable is high and wraps to 0.
  - tick = (count == RATE_DIV-1).
  - Held at 0 while enable is low.
- FSM:
  - IDLE: dac_data = MID. Goes to PREFILL when enable = 1.
  - PREFILL: dac_data = MID. Goes to STREAM when fill_level ≥ PREFILL_LEVEL (checked every cycle).
  - STREAM: on tick with FIFO non-empty, pop the head into dac_data. On tick with FIFO empty, dac_data ← MID, set underflow, go to PREFILL.
  - Any state: enable = 0 → IDLE next edge. FIFO is flushed (pointers = 0), dac_data ← MID, and writes are ignored.
- dac_strobe pulses on every tick in every state while enable = 1, including mid-scale outputs, so the DAC sees a continuous rate.
- Empty FIFO plus a write on the same edge as a tick: the pop sees empty (no bypass), so underflow applies.
- Simultaneous write and pop on a non-full, non-empty FIFO: fill_level is unchanged.
- Pointers wrap modulo depth. full = (fill_level == 2**ADDR_W). empty = (fill_level == 0).
- clear_flags clears both flags. If a new set event occurs in the same cycle, set wins.
- Asynchronous reset assertion mid-stream forces all reset values immediately; no drain.

## Timing
- A write at edge N is reflected in fill_level after edge N.
- A popped sample appears on dac_data on the same edge that raises dac_strobe; both are registered with no combinational path from inputs.
- The first dac_strobe occurs RATE_DIV edges after enable rises (first tick).
- Minimum latency from sample_in to dac_data is the first tick after the PREFILL_LEVEL-th sample is stored.
- Steady state: exactly one sample per RATE_DIV clocks. Sustained input above that rate leads to overflow.

## Configuration
- DAC_BUF_OFFSET_BINARY_EN defined:
  - dac_data = {~s[15], s[14:0]}, where s is the popped sample (offset binary for the DAC).
  - MID = 16'h8000.
- DAC_BUF_OFFSET_BINARY_EN undefined:
  - dac_data = s, unchanged two's complement.
  - MID = 16'h0000.
- The FIFO always stores raw two's complement; conversion happens only at the output register.

## Test plan
Defaults (ADDR_W = 4, RATE_DIV = 4, PREFILL_LEVEL = 8) and macro defined, unless stated otherwise.
- Reset/idle: rst_n low, then enable = 1 with no samples. dac_data = 16'h8000, strobe every 4 clocks, streaming = 0, flags 0.
- Prefill and stream: write 8 samples 0x0001..0x0008 back-to-back. streaming rises after the 8th write. The next strobes output 0x8001..0x8008, one per 4 clocks.
- Underflow: after those 8 outputs, the next tick outputs 0x8000, underflow = 1, FSM returns to PREFILL. clear_flags → underflow = 0.
- Overflow: write 17 samples with no streaming (PREFILL_LEVEL = 16). fill_level = 16 and overflow = 1. The 17th sample is never output.
- Enable drop mid-stream: enable = 0 while fill_level = 5. Next edge gives fill_level = 0, dac_data = 16'h8000, dac_strobe = 0, streaming = 0.
- Macro undefined: input 0xFFFF (-1) outputs 0xFFFF, and the idle value is 0x0000.

Source files
------------

// File: rtl/dac_output_buffer.sv
// Elastic sample FIFO and paced DAC output register. Samples are buffered until a prefill
// level is reached, then one is emitted every RATE_DIV clocks; mid-scale is held otherwise.
// Define DAC_BUF_OFFSET_BINARY_EN to emit offset-binary words (mid-scale 16'h8000) instead of two's complement.
module dac_output_buffer #(
   parameter int ADDR_W        = 4,
   parameter int RATE_DIV      = 4,
   parameter int PREFILL_LEVEL = 8
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [15:0]       sample_in,
   input  logic              sample_valid,
   input  logic              clear_flags,
   output logic [15:0]       dac_data,
   output logic              dac_strobe,
   output logic [ADDR_W:0]   fill_level,
   output logic              streaming,
   output logic              overflow,
   output logic              underflow
);

   // state     | meaning
   // S_IDLE    | disabled or just enabled; DAC at mid-scale
   // S_PREFILL | collecting samples until fill reaches PREFILL_LEVEL; DAC at mid-scale
   // S_STREAM  | popping one sample per pace tick into the DAC register

   localparam int DEPTH = 1 << ADDR_W;
   localparam int CNT_W = (RATE_DIV > 2) ? $clog2(RATE_DIV) : 1;
   localparam logic [CNT_W-1:0]  PACE_LAST = CNT_W'(RATE_DIV - 1);
   localparam logic [ADDR_W:0]   FULL_LVL  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]   PRE_LVL   = (ADDR_W + 1)'(PREFILL_LEVEL);

`ifdef DAC_BUF_OFFSET_BINARY_EN
   localparam logic [15:0] MID = 16'h8000;
   function automatic logic [15:0] to_dac(input logic [15:0] s);
      return {~s[15], s[14:0]};
   endfunction
`else
   localparam logic [15:0] MID = 16'h0000;
   function automatic logic [15:0] to_dac(input logic [15:0] s);
      return s;
   endfunction
`endif

   typedef enum logic [1:0] {S_IDLE, S_PREFILL, S_STREAM} state_t;

   state_t              state, state_n;
   logic [CNT_W-1:0]    pace_cnt;
   logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
   logic [15:0]         mem [DEPTH];
   logic                tick, full, empty, wr_en, ovf_set, pop, udf_set;

   assign tick    = enable & (pace_cnt == PACE_LAST);
   assign full    = (fill_level == FULL_LVL);
   assign empty   = (fill_level == '0);
   // full is judged on the pre-edge level, so a same-edge pop never frees a slot for a write
   assign wr_en   = sample_valid & enable & ~full;
   assign ovf_set = sample_valid & enable & full;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         pace_cnt <= '0;
      end else if (!enable || pace_cnt == PACE_LAST) begin
         pace_cnt <= '0;
      end else begin
         pace_cnt <= pace_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      if (!enable) begin
         state_n = S_IDLE;
      end else begin
         case (state)
            S_IDLE:    state_n = S_PREFILL;
            S_PREFILL: if (fill_level >= PRE_LVL) state_n = S_STREAM;
            S_STREAM:  if (tick && empty) state_n = S_PREFILL;
            default:   state_n = S_IDLE;
         endcase
      end
   end

   always_comb begin
      streaming = (state == S_STREAM);
      pop       = streaming & tick & ~empty;
      udf_set   = streaming & tick & empty;
   end

   always_ff @(posedge clk_in) begin
      if (wr_en) begin
         mem[wr_ptr] <= sample_in;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_level <= '0;
      end else if (!enable) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_level <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (pop)   rd_ptr <= rd_ptr + ADDR_W'(1);
         case ({wr_en, pop})
            2'b10:   fill_level <= fill_level + (ADDR_W + 1)'(1);
            2'b01:   fill_level <= fill_level - (ADDR_W + 1)'(1);
            default: fill_level <= fill_level;
         endcase
      end
   end

   // every tick strobes the DAC, so mid-scale words keep the sample rate continuous
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         dac_data   <= MID;
         dac_strobe <= 1'b0;
      end else if (!enable) begin
         dac_data   <= MID;
         dac_strobe <= 1'b0;
      end else begin
         dac_strobe <= tick;
         if (pop) begin
            dac_data <= to_dac(mem[rd_ptr]);
         end else if (tick) begin
            dac_data <= MID;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (ovf_set)          overflow <= 1'b1;
         else if (clear_flags) overflow <= 1'b0;
         if (udf_set)          underflow <= 1'b1;
         else if (clear_flags) underflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dac_output_buffer.sv
// Scoreboard bench for dac_output_buffer: a queue-based reference model predicts every
// post-edge status and every strobed DAC word; a separate monitor compares at the falling edge.
module tb_dac_output_buffer;

   localparam int ADDR_W        = 4;
   localparam int RATE_DIV      = 4;
   localparam int PREFILL_LEVEL = 8;
   localparam int DEPTH         = 1 << ADDR_W;

`ifdef DAC_BUF_OFFSET_BINARY_EN
   localparam logic [15:0] MID = 16'h8000;
   function automatic logic [15:0] conv(input logic [15:0] s);
      return s ^ 16'h8000;
   endfunction
`else
   localparam logic [15:0] MID = 16'h0000;
   function automatic logic [15:0] conv(input logic [15:0] s);
      return s;
   endfunction
`endif

   logic              clk_in = 1'b0;
   logic              rst_n = 1'b0;
   logic              enable = 1'b0;
   logic [15:0]       sample_in = '0;
   logic              sample_valid = 1'b0;
   logic              clear_flags = 1'b0;
   logic [15:0]       dac_data;
   logic              dac_strobe;
   logic [ADDR_W:0]   fill_level;
   logic              streaming;
   logic              overflow;
   logic              underflow;

   always #5 clk_in = ~clk_in;

   dac_output_buffer #(
      .ADDR_W(ADDR_W), .RATE_DIV(RATE_DIV), .PREFILL_LEVEL(PREFILL_LEVEL)
   ) dut (
      .clk_in(clk_in), .rst_n(rst_n), .enable(enable), .sample_in(sample_in),
      .sample_valid(sample_valid), .clear_flags(clear_flags), .dac_data(dac_data),
      .dac_strobe(dac_strobe), .fill_level(fill_level), .streaming(streaming),
      .overflow(overflow), .underflow(underflow)
   );

   typedef struct {
      int          cyc;
      logic [15:0] data;
      logic        strobe;
      int          fill;
      logic        strm;
      logic        ovf;
      logic        udf;
   } exp_t;

   exp_t        st_q[$];
   logic [15:0] data_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;

   // reference model state
   logic [15:0] mq[$];
   int          mode = 0;       // 0 idle, 1 prefill, 2 stream
   int          en_cnt = 0;     // edges seen with enable high since it last rose
   logic [15:0] m_data = MID;
   logic        m_strobe = 1'b0;
   logic        m_ovf = 1'b0;
   logic        m_udf = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk_in);
      cyc <= cyc + 1;
   end

   // monitor: status every cycle, DAC words whenever the DUT strobes
   initial forever begin
      @(negedge clk_in);
      while (st_q.size() > 0 && st_q[0].cyc < cyc) begin
         chk("stale_expectation", 32'(st_q[0].cyc), 32'(cyc));
         void'(st_q.pop_front());
      end
      if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
         exp_t e;
         e = st_q.pop_front();
         chk("dac_strobe", 32'(dac_strobe), 32'(e.strobe));
         chk("dac_data", 32'(dac_data), 32'(e.data));
         chk("fill_level", 32'(fill_level), 32'(e.fill));
         chk("streaming", 32'(streaming), 32'(e.strm));
         chk("overflow", 32'(overflow), 32'(e.ovf));
         chk("underflow", 32'(underflow), 32'(e.udf));
      end
      if (rst_n && dac_strobe) begin
         if (data_q.size() == 0) begin
            chk("unexpected_strobe", 32'(dac_strobe), 32'd0);
         end else begin
            chk("strobed_word", 32'(dac_data), 32'(data_q.pop_front()));
         end
      end
   end

   // drive one cycle of inputs and predict the state after the following edge
   task automatic step(input logic en, input logic v, input logic [15:0] s, input logic clr);
      int   pre;
      logic tick, set_o, set_u;
      exp_t e;
      @(posedge clk_in);
      #1;
      enable = en; sample_valid = v; sample_in = s; clear_flags = clr;
      set_o = 1'b0; set_u = 1'b0;
      if (!en) begin
         mq.delete();
         mode = 0; en_cnt = 0; m_strobe = 1'b0; m_data = MID;
      end else begin
         pre = mq.size();
         en_cnt++;
         tick = ((en_cnt % RATE_DIV) == 0);
         set_o = v && (pre == DEPTH);
         m_strobe = tick;
         if (tick) begin
            if (mode == 2 && pre > 0) begin
               m_data = conv(mq.pop_front());
            end else begin
               m_data = MID;
               if (mode == 2) set_u = 1'b1;
            end
            data_q.push_back(m_data);
         end
         if (v && pre < DEPTH) mq.push_back(s);
         case (mode)
            0: mode = 1;
            1: if (pre >= PREFILL_LEVEL) mode = 2;
            default: if (set_u) mode = 1;
         endcase
      end
      m_ovf = set_o ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_udf = set_u ? 1'b1 : (clr ? 1'b0 : m_udf);
      e.cyc = cyc + 1; e.data = m_data; e.strobe = m_strobe; e.fill = mq.size();
      e.strm = (mode == 2); e.ovf = m_ovf; e.udf = m_udf;
      st_q.push_back(e);
   endtask

   initial begin
      int pv;
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      chk("reset_dac_data", 32'(dac_data), 32'(MID));
      chk("reset_strobe", 32'(dac_strobe), 32'd0);
      chk("reset_fill", 32'(fill_level), 32'd0);
      chk("reset_streaming", 32'(streaming), 32'd0);
      chk("reset_flags", 32'({overflow, underflow}), 32'd0);
      rst_n = 1'b1;

      // idle with enable: mid-scale strobes every RATE_DIV clocks
      repeat (12) step(1'b1, 1'b0, 16'h0, 1'b0);
      // prefill with 1..8, stream them out, then underflow and clear
      for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 16'(i), 1'b0);
      repeat (44) step(1'b1, 1'b0, 16'h0, 1'b0);
      step(1'b1, 1'b0, 16'h0, 1'b1);
      repeat (6) step(1'b1, 1'b0, 16'h0, 1'b0);
      // burst to overflow, then drop enable mid-stream
      repeat (30) step(1'b1, 1'b1, 16'($urandom), 1'b0);
      repeat (2) step(1'b0, 1'b1, 16'($urandom), 1'b0);
      step(1'b1, 1'b0, 16'h0, 1'b1);

      // randomized regimes of input density with sparse enable drops and clears
      for (int r = 0; r < 16; r++) begin
         case (r % 4)
            0: pv = 90;
            1: pv = 10;
            2: pv = 25;
            default: pv = 50;
         endcase
         for (int k = 0; k < 150; k++) begin
            step(($urandom_range(199) != 0), ($urandom_range(99) < pv),
                 16'($urandom), ($urandom_range(99) < 3));
         end
      end

      repeat (120) step(1'b1, 1'b0, 16'h0, 1'b0);
      repeat (2) step(1'b0, 1'b0, 16'h0, 1'b0);
      repeat (3) @(negedge clk_in);
      chk("words_left_in_scoreboard", 32'(data_q.size()), 32'd0);
      chk("status_left_in_scoreboard", 32'(st_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
